// File: rtl/conversor_comp2_pkg.sv
// Shared ALU definitions: default operand width, the most-negative pattern
// and the register reset value used by the negation unit.
package conversor_comp2_pkg;

   localparam int DEFAULT_WIDTH = 6;
   localparam int MAX_WIDTH     = 64;

   localparam logic [MAX_WIDTH-1:0] RESET_VALUE = '0;

   // Callers truncate the result to their own operand width.
   function automatic logic [MAX_WIDTH-1:0] most_negative(input int width);
      logic [MAX_WIDTH-1:0] one;
      one = 1;
      return one << (width - 1);
   endfunction

endpackage

// File: rtl/comp2_incrementer.sv
// Combinational ripple-carry +cin over a WIDTH-bit operand; the full carry
// chain is exported so the adder's carry-in path can reuse this block.
module comp2_incrementer
   import conversor_comp2_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic             cin_i,
   output logic [WIDTH-1:0] sum_o,
   output logic [WIDTH:0]   carry_o
);

   always_comb begin
      logic c;
      // NOTE: blocking assignments here so the running carry updates within one evaluation.
      sum_o   = '0;
      carry_o = '0;
      c       = cin_i;
      for (int i = 0; i < WIDTH; i++) begin
         carry_o[i] = c;
         sum_o[i]   = a_i[i] ^ c;
         c          = a_i[i] & c;
      end
      carry_o[WIDTH] = c;
   end

endmodule

// File: rtl/conversor_comp2.sv
// Registered two's-complement negation: A_convertido <= ~A + 1 and ovf flags
// the most-negative operand; both outputs appear one clock after A is sampled.
module conversor_comp2
   import conversor_comp2_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] A_convertido,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MOST_NEG  = WIDTH'(most_negative(WIDTH));
   localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VALUE);

   logic [WIDTH-1:0] a_inv;
   logic [WIDTH-1:0] a_conv_d, a_conv_q;
   logic             ovf_d, ovf_q;
   // Only the adder's carry-in path consumes the chain; negation needs the sum.
   logic [WIDTH:0]   carry_unused;

   assign a_inv = ~A;

   comp2_incrementer #(
      .WIDTH (WIDTH)
   ) u_incrementer (
      .a_i     (a_inv),
      .cin_i   (1'b1),
      .sum_o   (a_conv_d),
      .carry_o (carry_unused)
   );

   assign ovf_d = (A == MOST_NEG);

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments for registered state avoid simulation ordering races.
      if (rst) begin
         a_conv_q <= RESET_VAL;
         ovf_q    <= 1'b0;
      end else begin
         a_conv_q <= a_conv_d;
         ovf_q    <= ovf_d;
      end
   end

   assign A_convertido = a_conv_q;
   assign ovf          = ovf_q;

endmodule

// File: tb/tb_conversor_comp2.sv
// Directed bench for conversor_comp2: reset, identity and boundary vectors,
// a full 6-bit sweep, mid-stream reset and an 8-bit instance.
module tb_conversor_comp2;

   logic       clk;
   logic       rst;
   logic [5:0] a6;
   logic [5:0] conv6;
   logic       ovf6;
   logic [7:0] a8;
   logic [7:0] conv8;
   logic       ovf8;

   int n_checks;
   int n_pass;

   conversor_comp2 #(
      .WIDTH (6)
   ) dut6 (
      .clk          (clk),
      .rst          (rst),
      .A            (a6),
      .A_convertido (conv6),
      .ovf          (ovf6)
   );

   conversor_comp2 #(
      .WIDTH (8)
   ) dut8 (
      .clk          (clk),
      .rst          (rst),
      .A            (a8),
      .A_convertido (conv8),
      .ovf          (ovf8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
      n_checks++;
      if (actual === expected) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %b, expected %b", tag, actual, expected);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [5:0] a;
      logic [5:0] res;
      logic       ovf;
      string      tag;
   } vec_t;

   vec_t vecs[6];

   initial begin
      n_checks = 0;
      n_pass   = 0;
      rst      = 1'b1;
      a6       = 6'b010101;
      a8       = 8'h00;

      // Reset held for three edges with a nonzero operand.
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("reset_val_%0d", i), {2'b00, conv6}, 8'h00);
         check($sformatf("reset_ovf_%0d", i), {7'b0, ovf6}, 8'h00);
      end
      check("reset_val_w8", conv8, 8'h00);

      rst = 1'b0;
      step();
      check("post_reset_val", {2'b00, conv6}, {2'b00, 6'b101011});
      check("post_reset_ovf", {7'b0, ovf6}, 8'h00);

      // Outputs must not follow A between edges.
      a6 = 6'b000111;
      #2;
      check("no_comb_path", {2'b00, conv6}, {2'b00, 6'b101011});

      vecs[0] = '{6'b000000, 6'b000000, 1'b0, "zero"};
      vecs[1] = '{6'b000001, 6'b111111, 1'b0, "plus_one"};
      vecs[2] = '{6'b111111, 6'b000001, 1'b0, "minus_one"};
      vecs[3] = '{6'b011111, 6'b100001, 1'b0, "most_pos"};
      vecs[4] = '{6'b100000, 6'b100000, 1'b1, "most_neg"};
      vecs[5] = '{6'b100001, 6'b011111, 1'b0, "most_neg_plus1"};
      foreach (vecs[i]) begin
         a6 = vecs[i].a;
         step();
         check({vecs[i].tag, "_val"}, {2'b00, conv6}, {2'b00, vecs[i].res});
         check({vecs[i].tag, "_ovf"}, {7'b0, ovf6}, {7'b0, vecs[i].ovf});
      end

      // Sweep: a counter toggles bit k every 2^k cycles, covering all 64 values back to back.
      for (int v = 0; v < 64; v++) begin
         int exp_val;
         a6 = 6'(v);
         step();
         exp_val = (64 - v) % 64;
         check($sformatf("sweep_val_%0d", v), {2'b00, conv6}, 8'(exp_val));
         check($sformatf("sweep_ovf_%0d", v), {7'b0, ovf6}, {7'b0, (v == 32)});
      end

      // Reset asserted mid-stream wins over the operand of that cycle.
      a6 = 6'd3;
      step();
      check("mid_a3", {2'b00, conv6}, {2'b00, 6'b111101});
      a6  = 6'd4;
      rst = 1'b1;
      step();
      check("mid_rst_val", {2'b00, conv6}, 8'h00);
      check("mid_rst_ovf", {7'b0, ovf6}, 8'h00);
      a6  = 6'd5;
      rst = 1'b0;
      step();
      check("mid_a5", {2'b00, conv6}, {2'b00, 6'b111011});

      // Wider instance.
      a8 = 8'b1000_0000;
      step();
      check("w8_most_neg_val", conv8, 8'b1000_0000);
      check("w8_most_neg_ovf", {7'b0, ovf8}, 8'h01);
      a8 = 8'b0000_0010;
      step();
      check("w8_two_val", conv8, 8'b1111_1110);
      check("w8_two_ovf", {7'b0, ovf8}, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/conversor_comp2.md
# conversor_comp2

Registered two's-complement negation unit for the ALU datapath. It takes a signed operand A and produces −A (bitwise invert plus one). The result and an overflow flag appear one clock later. It sits in front of the adder so that subtraction can be performed as A + (−B), and it is also used for explicit negate operations.

## Interface
- `WIDTH`, default 6: operand and result width in bits. Minimum 2.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `A`  input  WIDTH  signed operand in two's complement.
- `A_convertido`  output  WIDTH  registered two's complement of A, i.e. (~A + 1) mod 2^WIDTH.
- `ovf`  output  1  registered flag; 1 when A is the most-negative value, which has no representable negation.

## Operation
- Each rising clk edge with rst=0 computes the next values:
  - `A_convertido` ← (~A + 1) truncated to WIDTH bits.
  - `ovf` ← (A == {1'b1, {WIDTH-1{1'b0}}}).
- Arithmetic is modulo 2^WIDTH and the carry-out is discarded.
  - A=0 yields 0 with ovf=0.
  - A=most-negative yields the same value (e.g. 100000 for WIDTH=6) with ovf=1.
- For every other A: `A_convertido` = −A exactly, ovf=0, and the sign bit of the result is the inverse of A's sign bit.
- The block is stateless apart from the output registers. There is no enable or handshake, so a new operand is accepted every cycle.
- X on A propagates to the outputs. No X-filtering is performed.

## Timing
- Latency is 1 cycle: the value on A sampled at edge n appears on the outputs after edge n.
- Throughput is 1 operand per cycle. Back-to-back changes of A on consecutive cycles produce back-to-back results.
- Reset:
  - When rst=1 at a rising edge, `A_convertido` becomes 0 and `ovf` becomes 0, regardless of A.
  - Reset takes priority over the computation, including when asserted mid-stream.
  - The first result after reset deasserts is the one sampled at the first edge with rst=0.
- Outputs change only on rising clk edges. There are no combinational paths from A to any output.
- The increment is a ripple carry chain of WIDTH stages. It must close timing at the ALU clock for WIDTH ≤ 32.

## Structure
- Shared ALU package holds:
  - default `WIDTH` (6);
  - a function or constant giving the most-negative pattern for a given WIDTH;
  - the reset-value constant (all zeros).
- Sub-module `comp2_incrementer`: purely combinational, WIDTH-bit +1 on the inverted operand. It exposes the sum and the carry chain, and is reusable by the ALU adder's carry-in path.
- The top level `conversor_comp2` contains the inversion, the instance of `comp2_incrementer`, the overflow detect, and the output registers.

## Test plan
- **Reset:** hold rst=1 for 3 cycles with A=010101 → `A_convertido`=000000, ovf=0 on every cycle. Release rst → next edge gives 101011.
- **Identity points (WIDTH=6):** A=000000 → 000000, ovf=0. A=000001 → 111111. A=111111 → 000001.
- **Boundaries:** A=011111 → 100001, ovf=0. A=100000 → 100000, ovf=1. A=100001 → 011111, ovf=0.
- **Exhaustive sweep:** A[k] toggles every 2^k time units, for k=0..5, so all 64 values appear. Check that each output equals (64 − A) mod 64 exactly one cycle after A was sampled, and that ovf is 1 only for A=32.
- **Mid-stream reset:** stream A=3,4,5 on consecutive cycles with rst=1 asserted at the cycle of 4 → outputs are 111101, then 000000, then 111011.
- **Parameter check:** WIDTH=8 with A=10000000 gives 10000000 and ovf=1. A=00000010 gives 11111110.
